// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: two-requester round-robin front end feeding a
// sequential 8-bit binary to 3-digit BCD converter (double dabble).
module bcd_conv_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_id,
  output logic [3:0] out_hundreds,
  output logic [3:0] out_tens,
  output logic [3:0] out_ones,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [7:0] opnd;
  logic [2:0] cnt;
  logic       last;
  logic       id;
  logic [3:0] hun;
  logic [3:0] ten;
  logic [3:0] one;

  logic       gnt1;
  logic       take;
  logic [2:0] hun_a;
  logic [3:0] ten_a;
  logic [3:0] one_a;

  function automatic logic [3:0] adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // last=1 means req1 was served last, so req0 wins a tie
  always_comb begin
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid): gnt1 = ~last;
      (req1_valid & ~req0_valid): gnt1 = 1'b1;
      default: gnt1 = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = ~gnt1;
        req1_ready = gnt1;
        take       = gnt1 ? req1_valid : req0_valid;
        if (take) state_nx = SHIFT;
      end
      SHIFT: begin
        if (cnt == 3'd7) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // hundreds never exceeds 2 for an 8-bit operand, so only 3 bits
  // survive the shift out of the top digit
  always_comb begin
    hun_a = (hun >= 4'd5) ? hun[2:0] + 3'd3 : hun[2:0];
    ten_a = adj(ten);
    one_a = adj(one);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd <= '0;
      cnt  <= '0;
      last <= 1'b1;
      id   <= 1'b0;
      hun  <= '0;
      ten  <= '0;
      one  <= '0;
    end else if (state == IDLE) begin
      if (take) begin
        opnd <= gnt1 ? req1_data : req0_data;
        id   <= gnt1;
        last <= gnt1;
        cnt  <= '0;
        hun  <= '0;
        ten  <= '0;
        one  <= '0;
      end
    end else if (state == SHIFT) begin
      hun  <= {hun_a, ten_a[3]};
      ten  <= {ten_a[2:0], one_a[3]};
      one  <= {one_a[2:0], opnd[7]};
      opnd <= {opnd[6:0], 1'b0};
      cnt  <= cnt + 3'd1;
    end
  end

  assign out_id       = id;
  assign out_hundreds = hun;
  assign out_tens     = ten;
  assign out_ones     = one;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: scoreboard bench for bcd_conv_sched with an
// arithmetic reference model and round-robin grant model.
module tb_bcd_conv_sched;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_id;
  logic [3:0] out_hundreds;
  logic [3:0] out_tens;
  logic [3:0] out_ones;
  logic       busy;

  typedef struct {
    bit id;
    int val;
  } exp_t;

  exp_t sb[$];
  int   vec;
  int   err;
  bit   last_m;

  bcd_conv_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .out_hundreds (out_hundreds),
    .out_tens     (out_tens),
    .out_ones     (out_ones),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit model_grant(input bit v0, input bit v1,
                                     input bit lst);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    if (v0 && v1)  return ~lst;
    return 1'b0;
  endfunction

  // monitor: checks every handed-off result against the scoreboard
  initial begin
    exp_t e;
    int   h, t, o;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vec++;
        if (sb.size() == 0) begin
          err++;
          $display("FAIL spurious_result: got id=%0d %0d/%0d/%0d, none expected",
                   out_id, out_hundreds, out_tens, out_ones);
        end else begin
          e = sb.pop_front();
          h = e.val / 100;
          t = (e.val / 10) % 10;
          o = e.val % 10;
          if (out_id !== e.id || out_hundreds !== 4'(h) ||
              out_tens !== 4'(t) || out_ones !== 4'(o)) begin
            err++;
            $display("FAIL result(%0d): got id=%0d %0d/%0d/%0d want id=%0d %0d/%0d/%0d",
                     e.val, out_id, out_hundreds, out_tens, out_ones,
                     e.id, h, t, o);
          end
        end
      end
    end
  end

  task automatic issue(input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1);
    bit   g;
    bit   done;
    exp_t e;
    @(posedge clk); #1;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
        done = 1'b1;
    end
    vec++;
    if (!done) begin
      err++;
      $display("FAIL accept_timeout: got no handshake, want one within 60 cycles");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    g = model_grant(v0, v1, last_m);
    if (req1_ready !== g || req0_ready !== ~g) begin
      err++;
      $display("FAIL grant: got r0=%0d r1=%0d want req%0d",
               req0_ready, req1_ready, g);
    end
    e.id  = g;
    e.val = int'(g ? d1 : d0);
    sb.push_back(e);
    last_m = g;
    @(posedge clk); #1;
    if (g) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int n = 0; n < 400 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
      out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
    out_ready = 1'b1;
    vec++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         seen;
    vec = 0;
    err = 0;
    last_m = 1'b1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_id !== 1'b0 ||
        {out_hundreds, out_tens, out_ones} !== 12'h000 ||
        req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      err++;
      $display("FAIL reset_state: got busy=%0d ov=%0d id=%0d d=%h r0=%0d r1=%0d want 0 0 0 000 1 0",
               busy, out_valid, out_id, {out_hundreds, out_tens, out_ones},
               req0_ready, req1_ready);
    end

    // tie after reset, then the loser, then a repeat tie
    issue(1'b1, 8'd42, 1'b1, 8'd200);
    issue(1'b0, 8'd0, 1'b1, 8'd200);
    issue(1'b1, 8'd17, 1'b1, 8'd231);
    issue(1'b0, 8'd0, 1'b1, 8'd231);
    drain(1'b0);

    issue(1'b1, 8'd173, 1'b0, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 8) begin
        vec++;
        if (out_valid !== 1'b0) begin
          err++;
          $display("FAIL latency_early: got out_valid=%0d at cycle 8, want 0", out_valid);
        end
      end
      if (k == 9) begin
        vec++;
        if (out_valid !== 1'b1) begin
          err++;
          $display("FAIL latency: got out_valid=%0d at cycle 9, want 1", out_valid);
        end
      end
      if (k == 10) begin
        vec++;
        if (busy !== 1'b0) begin
          err++;
          $display("FAIL busy_after: got busy=%0d, want 0", busy);
        end
      end
    end
    drain(1'b0);

    out_ready = 1'b0;
    issue(1'b1, 8'd99, 1'b0, 8'd0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = (out_valid === 1'b1);
    end
    vec++;
    if (!seen) begin
      err++;
      $display("FAIL hold_timeout: got out_valid=0, want 1 within 20 cycles");
    end
    repeat (5) begin
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b1 ||
          {out_hundreds, out_tens, out_ones} !== 12'h099) begin
        err++;
        $display("FAIL backpressure: got ov=%0d d=%h, want 1 099",
                 out_valid, {out_hundreds, out_tens, out_ones});
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(1'b0);

    issue(1'b1, 8'd77, 1'b0, 8'd0);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 ||
        {out_hundreds, out_tens, out_ones} !== 12'h000 ||
        req0_ready !== 1'b1) begin
      err++;
      $display("FAIL mid_reset: got busy=%0d ov=%0d d=%h r0=%0d want 0 0 000 1",
               busy, out_valid, {out_hundreds, out_tens, out_ones}, req0_ready);
    end
    issue(1'b1, 8'd5, 1'b0, 8'd0);
    drain(1'b0);

    issue(1'b0, 8'd0, 1'b1, 8'd60);
    for (int k = 0; k < 6; k++) begin
      req1_valid = 1'b1;
      req1_data  = 8'($urandom);
      req0_valid = 1'b1;
      req0_data  = 8'($urandom);
      @(negedge clk);
      vec++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        err++;
        $display("FAIL busy_ignore: got r0=%0d r1=%0d busy=%0d want 0 0 1",
                 req0_ready, req1_ready, busy);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain(1'b0);

    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) issue(1'b1, 8'(i), 1'b0, 8'd0);
      else            issue(1'b0, 8'd0, 1'b1, 8'(i));
    end
    drain(1'b0);

    for (int i = 0; i < 120; i++) begin
      v0 = ($urandom_range(0, 1) != 0);
      v1 = v0 ? ($urandom_range(0, 1) != 0) : 1'b1;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      issue(v0, d0, v1, d1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (i % 3 == 0) drain(1'b1);
    end
    drain(1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and result is 3 BCD digits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 (operand-entry path) has an operand.
REQ-005 req0_data  input  8  requester 0 unsigned binary operand.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle when req0_valid is also high.
REQ-007 req1_valid  input  1  requester 1 (ALU-result path) has an operand.
REQ-008 req1_data  input  8  requester 1 unsigned binary operand.
REQ-009 req1_ready  output  1  requester 1 operand accepted this cycle when req1_valid is also high.
REQ-010 out_valid  output  1  converted result is available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_id  output  1  index of the requester that owns the current result.
REQ-013 out_hundreds, out_tens, out_ones  output  4 each  BCD digits of the result.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT, HOLD.
REQ-016 In IDLE, exactly one of req0_ready/req1_ready SHALL be high: the granted requester. The ready signals SHALL be combinational from state, valids and the last-grant flag.
REQ-017 Grant when only one valid: grant that requester.
REQ-018 Grant when both are valid: grant the requester NOT served last (round-robin).
REQ-019 Grant when neither is valid: req0_ready=1.
REQ-020 Both ready signals SHALL be 0 outside IDLE; requester valids and data SHALL be ignored outside IDLE.
REQ-021 A transfer (valid & ready in IDLE) SHALL latch the operand and the requester index, update the last-grant flag, clear the digit registers and the bit counter, and move to SHIFT.
REQ-022 SHIFT SHALL last exactly 8 cycles, MSB first. Each cycle:
  - first add 3 to every digit register >= 5;
  - then shift the 12-bit digit chain {hundreds,tens,ones} left by one, inserting the operand's next bit into ones[0].
REQ-023 After the 8th SHIFT cycle the FSM SHALL enter HOLD.
REQ-024 Latency: with transfer at edge T, out_valid SHALL be high from the cycle after edge T+8 (9 cycles after acceptance).
REQ-025 In HOLD:
  - out_valid SHALL be 1;
  - out_id and the digits SHALL be stable until out_valid & out_ready;
  - on that transfer the FSM SHALL return to IDLE.
REQ-026 out_valid SHALL be 0 in IDLE and SHIFT; the digit outputs SHALL reflect the digit registers at all times.
REQ-027 Minimum throughput: one conversion per 10 cycles; there is no acceptance in the same cycle as result handoff.
REQ-028 Operand 0 SHALL yield 0/0/0; operand 255 SHALL yield 2/5/5; every digit SHALL be <= 9 for all 256 operands.

Reset
REQ-029 When rst=1 at a clock edge:
  - state SHALL become IDLE;
  - all digit registers, out_id and the bit counter SHALL become 0;
  - the last-grant flag SHALL become "requester 1" so req0 wins the first tie.
REQ-030 Reset SHALL take priority over every other event. Asserting it during SHIFT or HOLD SHALL abort the operation with no out_valid pulse.

Verification
REQ-031 Single request: req0 sends 8'd173, out_ready=1 -> out_valid rises 9 cycles after acceptance with 1/7/3, out_id=0, busy low next cycle.
REQ-032 Tie and round-robin:
  - after reset, both valid with 8'd42 and 8'd200 -> req0 served first (0/4/2, id 0), then req1 (2/0/0, id 1);
  - a repeat tie -> req0 served again.
REQ-033 Backpressure: out_ready=0 for 5 cycles in HOLD with operand 8'd99 -> out_valid stays 1 and digits stay 0/9/9; the result is released on the first out_ready=1 cycle.
REQ-034 Mid-operation reset: rst pulsed on the 4th SHIFT cycle -> next cycle busy=0, out_valid=0, digits 0, req0_ready=1; a subsequent 8'd5 converts to 0/0/5.
REQ-035 Exhaustive: operands 0..255 alternated between requesters -> every result equals the decimal value, and out_id always matches the sender.
REQ-036 Ignore while busy: req1 changes data during SHIFT -> result is unchanged and req1_ready stays 0 until IDLE.
